// File: rtl/fabric_config_loader_if.sv
// Configuration word stream between a bitstream source and the fabric loader.
// The master drives words and valid; the loader answers with ready.
interface fabric_config_loader_if;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fabric_config_loader.sv
// Frame loader for the 8-cell LUT/switch-block fabric: assembles LUT and SB words,
// issues one-cycle write strobes, checks the XOR trailer, then enables the fabric.
module fabric_config_loader #(
    parameter int NUM_CELLS     = 8,
    parameter int LUTS_PER_CELL = 3,
    parameter int LUT_BITS      = 33,
    parameter int SB_BITS       = 16,
    localparam int CELL_W       = $clog2(NUM_CELLS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    fabric_config_loader_if.slave cfg,
    output logic [LUT_BITS-1:0] lut_wdata,
    output logic [CELL_W-1:0]   lut_cell,
    output logic [1:0]          lut_idx,
    output logic                lut_we,
    output logic [SB_BITS-1:0]  sb_wdata,
    output logic [CELL_W-1:0]   sb_cell,
    output logic                sb_we,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                fabric_en,
    output logic [6:0]          word_count
);
    localparam int FRAME_WORDS = NUM_CELLS * (2 * LUTS_PER_CELL + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LO, S_HI, S_SB, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t              state_reg;
    logic [CELL_W-1:0]   cell_reg;
    logic [1:0]          lut_reg;
    logic [31:0]         lo_word_reg;
    logic [31:0]         checksum_reg;
    logic [6:0]          word_count_reg;
    logic [LUT_BITS-1:0] lut_wdata_reg;
    logic [CELL_W-1:0]   lut_cell_reg;
    logic [1:0]          lut_idx_reg;
    logic                lut_we_reg;
    logic [SB_BITS-1:0]  sb_wdata_reg;
    logic [CELL_W-1:0]   sb_cell_reg;
    logic                sb_we_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                error_reg;
    logic                fabric_en_reg;

    logic ready;
    logic hs;
    logic hi_reserved_set;
    logic sb_reserved_set;

    assign ready = (state_reg == S_LO) || (state_reg == S_HI) ||
                   (state_reg == S_SB) || (state_reg == S_CHECK);
    assign hs    = cfg.cfg_valid && ready;
    // Only bit 0 of a LUT high word and the low SB_BITS of an SB word are meaningful.
    assign hi_reserved_set = |cfg.cfg_data[31:LUT_BITS-32];
    assign sb_reserved_set = |cfg.cfg_data[31:SB_BITS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            cell_reg       <= '0;
            lut_reg        <= '0;
            lo_word_reg    <= '0;
            checksum_reg   <= '0;
            word_count_reg <= '0;
            lut_wdata_reg  <= '0;
            lut_cell_reg   <= '0;
            lut_idx_reg    <= '0;
            lut_we_reg     <= 1'b0;
            sb_wdata_reg   <= '0;
            sb_cell_reg    <= '0;
            sb_we_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            fabric_en_reg  <= 1'b0;
        end else begin
            lut_we_reg <= 1'b0;
            sb_we_reg  <= 1'b0;

            if (hs && word_count_reg != 7'(FRAME_WORDS))
                word_count_reg <= word_count_reg + 7'd1;
            // The trailer itself is excluded from the running checksum.
            if (hs && state_reg != S_CHECK)
                checksum_reg <= checksum_reg ^ cfg.cfg_data;

            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_reg      <= S_LO;
                        cell_reg       <= CELL_W'(NUM_CELLS - 1);
                        lut_reg        <= '0;
                        word_count_reg <= '0;
                        checksum_reg   <= '0;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        error_reg      <= 1'b0;
                        fabric_en_reg  <= 1'b0;
                    end
                end
                S_LO: begin
                    if (hs) begin
                        lo_word_reg <= cfg.cfg_data;
                        state_reg   <= S_HI;
                    end
                end
                S_HI: begin
                    if (hs) begin
                        if (hi_reserved_set) begin
                            state_reg <= S_ERR;
                            busy_reg  <= 1'b0;
                            error_reg <= 1'b1;
                        end else begin
                            lut_wdata_reg <= {cfg.cfg_data[0], lo_word_reg};
                            lut_cell_reg  <= cell_reg;
                            lut_idx_reg   <= lut_reg;
                            lut_we_reg    <= 1'b1;
                            if (lut_reg == 2'(LUTS_PER_CELL - 1)) begin
                                state_reg <= S_SB;
                            end else begin
                                lut_reg   <= lut_reg + 2'd1;
                                state_reg <= S_LO;
                            end
                        end
                    end
                end
                S_SB: begin
                    if (hs) begin
                        if (sb_reserved_set) begin
                            state_reg <= S_ERR;
                            busy_reg  <= 1'b0;
                            error_reg <= 1'b1;
                        end else begin
                            sb_wdata_reg <= cfg.cfg_data[SB_BITS-1:0];
                            sb_cell_reg  <= cell_reg;
                            sb_we_reg    <= 1'b1;
                            if (cell_reg == '0) begin
                                state_reg <= S_CHECK;
                            end else begin
                                cell_reg  <= cell_reg - 1'b1;
                                lut_reg   <= '0;
                                state_reg <= S_LO;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (hs) begin
                        busy_reg <= 1'b0;
                        if (cfg.cfg_data == checksum_reg) begin
                            state_reg     <= S_DONE;
                            done_reg      <= 1'b1;
                            fabric_en_reg <= 1'b1;
                        end else begin
                            state_reg <= S_ERR;
                            error_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cfg.cfg_ready = ready;
    assign lut_wdata     = lut_wdata_reg;
    assign lut_cell      = lut_cell_reg;
    assign lut_idx       = lut_idx_reg;
    assign lut_we        = lut_we_reg;
    assign sb_wdata      = sb_wdata_reg;
    assign sb_cell       = sb_cell_reg;
    assign sb_we         = sb_we_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign error         = error_reg;
    assign fabric_en     = fabric_en_reg;
    assign word_count    = word_count_reg;
endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: table of frame scenarios plus
// hand-written restart and mid-load reset sequences, with a strobe scoreboard.
module tb_fabric_config_loader;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [32:0] lut_wdata;
    logic [2:0]  lut_cell;
    logic [1:0]  lut_idx;
    logic        lut_we;
    logic [15:0] sb_wdata;
    logic [2:0]  sb_cell;
    logic        sb_we;
    logic        busy, done, error, fabric_en;
    logic [6:0]  word_count;

    fabric_config_loader_if cfg ();

    fabric_config_loader dut (
        .clock(clock), .reset_n(reset_n), .start(start), .cfg(cfg),
        .lut_wdata(lut_wdata), .lut_cell(lut_cell), .lut_idx(lut_idx), .lut_we(lut_we),
        .sb_wdata(sb_wdata), .sb_cell(sb_cell), .sb_we(sb_we),
        .busy(busy), .done(done), .error(error), .fabric_en(fabric_en),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] frame [57];
    logic [32:0] exp_lut_data [24];
    logic [2:0]  exp_lut_cell [24];
    logic [1:0]  exp_lut_idx [24];
    logic [15:0] exp_sb_data [8];
    logic [2:0]  exp_sb_cell [8];
    int lut_cnt = 0;
    int sb_cnt = 0;
    bit prev_hs = 1'b0;

    typedef struct {
        int          bad_idx;
        logic [31:0] bad_val;
        logic [31:0] trl_xor;
        bit          gaps;
        int          start_at;
        bit          exp_done;
        bit          exp_err;
        int          exp_lut;
        int          exp_sb;
        int          exp_words;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every strobe must follow a handshake and match the next expected write.
    always @(negedge clock) begin
        if (reset_n) begin
            if (lut_we) begin
                chk("lut_we_after_handshake", 64'(prev_hs), 64'd1);
                if (lut_cnt < 24) begin
                    chk("lut_wdata", 64'(lut_wdata), 64'(exp_lut_data[lut_cnt]));
                    chk("lut_cell", 64'(lut_cell), 64'(exp_lut_cell[lut_cnt]));
                    chk("lut_idx", 64'(lut_idx), 64'(exp_lut_idx[lut_cnt]));
                end else begin
                    chk("lut_we_excess", 64'(lut_cnt), 64'd23);
                end
                lut_cnt++;
            end
            if (sb_we) begin
                chk("sb_we_after_handshake", 64'(prev_hs), 64'd1);
                if (sb_cnt < 8) begin
                    chk("sb_wdata", 64'(sb_wdata), 64'(exp_sb_data[sb_cnt]));
                    chk("sb_cell", 64'(sb_cell), 64'(exp_sb_cell[sb_cnt]));
                end else begin
                    chk("sb_we_excess", 64'(sb_cnt), 64'd7);
                end
                sb_cnt++;
            end
        end
        prev_hs = cfg.cfg_valid && cfg.cfg_ready;
    end

    task automatic build_frame(input int bad_idx, input logic [31:0] bad_val,
                               input logic [31:0] trl_xor);
        logic [31:0] x;
        for (int i = 0; i < 56; i++) begin
            if (i % 7 == 6)
                frame[i] = {16'h0, 16'h5A00 ^ 16'(i * 97)};
            else if ((i % 7) % 2 == 1)
                frame[i] = {31'h0, 1'((i / 2) % 2)};
            else
                frame[i] = 32'h9E3779B9 * 32'(i + 1);
        end
        for (int cp = 0; cp < 8; cp++) begin
            for (int l = 0; l < 3; l++) begin
                exp_lut_data[cp*3+l] = {frame[cp*7+2*l+1][0], frame[cp*7+2*l]};
                exp_lut_cell[cp*3+l] = 3'(7 - cp);
                exp_lut_idx[cp*3+l]  = 2'(l);
            end
            exp_sb_data[cp] = frame[cp*7+6][15:0];
            exp_sb_cell[cp] = 3'(7 - cp);
        end
        if (bad_idx >= 0) frame[bad_idx] = bad_val;
        x = 32'h0;
        for (int i = 0; i < 56; i++) x = x ^ frame[i];
        frame[56] = x ^ trl_xor;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, output bit ok);
        cfg.cfg_data  = w;
        cfg.cfg_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            if (cfg.cfg_ready) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_frame(input bit gaps, input int start_at, input int last,
                              output int accepted);
        bit ok;
        accepted = 0;
        for (int i = 0; i <= last; i++) begin
            if (i == start_at) start = 1'b1;
            send_word(frame[i], ok);
            start = 1'b0;
            if (!ok) break;
            accepted++;
            if (gaps) begin
                cfg.cfg_valid = 1'b0;
                @(posedge clock);
                #1;
            end
        end
        cfg.cfg_valid = 1'b0;
    endtask

    vec_t vecs [7];
    int   accepted;

    initial begin
        vecs[0] = '{-1, 32'h0, 32'h0, 1'b0, -1, 1'b1, 1'b0, 24, 8, 57};
        vecs[1] = '{-1, 32'h0, 32'h1, 1'b0, -1, 1'b0, 1'b1, 24, 8, 57};
        vecs[2] = '{17, 32'h3, 32'h0, 1'b0, -1, 1'b0, 1'b1, 7, 2, 18};
        vecs[3] = '{-1, 32'h0, 32'h0, 1'b1, -1, 1'b1, 1'b0, 24, 8, 57};
        vecs[4] = '{6, 32'h0001_0000, 32'h0, 1'b0, -1, 1'b0, 1'b1, 3, 0, 7};
        vecs[5] = '{-1, 32'h0, 32'h0, 1'b0, 10, 1'b1, 1'b0, 24, 8, 57};
        vecs[6] = '{-1, 32'h0, 32'h8000_0000, 1'b1, -1, 1'b0, 1'b1, 24, 8, 57};

        cfg.cfg_valid = 1'b0;
        cfg.cfg_data  = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_fabric_en", 64'(fabric_en), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_cfg_ready", 64'(cfg.cfg_ready), 64'd0);
        chk("rst_strobes", 64'({lut_we, sb_we}), 64'd0);
        chk("rst_lut_wdata", 64'(lut_wdata), 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_cfg_ready", 64'(cfg.cfg_ready), 64'd0);

        for (int v = 0; v < 7; v++) begin
            build_frame(vecs[v].bad_idx, vecs[v].bad_val, vecs[v].trl_xor);
            lut_cnt = 0;
            sb_cnt  = 0;
            do_start();
            chk($sformatf("v%0d_busy_at_start", v), 64'(busy), 64'd1);
            chk($sformatf("v%0d_count_at_start", v), 64'(word_count), 64'd0);
            send_frame(vecs[v].gaps, vecs[v].start_at, 56, accepted);
            repeat (2) @(posedge clock);
            #1;
            chk($sformatf("v%0d_done", v), 64'(done), 64'(vecs[v].exp_done));
            chk($sformatf("v%0d_error", v), 64'(error), 64'(vecs[v].exp_err));
            chk($sformatf("v%0d_fabric_en", v), 64'(fabric_en), 64'(vecs[v].exp_done));
            chk($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
            chk($sformatf("v%0d_word_count", v), 64'(word_count), 64'(vecs[v].exp_words));
            chk($sformatf("v%0d_accepted", v), 64'(accepted), 64'(vecs[v].exp_words));
            chk($sformatf("v%0d_lut_writes", v), 64'(lut_cnt), 64'(vecs[v].exp_lut));
            chk($sformatf("v%0d_sb_writes", v), 64'(sb_cnt), 64'(vecs[v].exp_sb));
            chk($sformatf("v%0d_cfg_ready", v), 64'(cfg.cfg_ready), 64'd0);
        end

        // Restart from DONE.
        build_frame(-1, 32'h0, 32'h0);
        lut_cnt = 0;
        sb_cnt  = 0;
        do_start();
        send_frame(1'b0, -1, 56, accepted);
        @(posedge clock);
        #1;
        chk("restart_pre_done", 64'(done), 64'd1);
        do_start();
        chk("restart_fabric_en", 64'(fabric_en), 64'd0);
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_word_count", 64'(word_count), 64'd0);

        // Reset in the middle of a load, just as a LUT strobe is high.
        lut_cnt = 0;
        sb_cnt  = 0;
        send_frame(1'b0, -1, 19, accepted);
        chk("midrst_accepted", 64'(accepted), 64'd20);
        chk("midrst_lut_we_pending", 64'(lut_we), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_lut_we", 64'(lut_we), 64'd0);
        chk("midrst_word_count", 64'(word_count), 64'd0);
        chk("midrst_cfg_ready", 64'(cfg.cfg_ready), 64'd0);
        chk("midrst_lut_wdata", 64'(lut_wdata), 64'd0);
        chk("midrst_fabric_en", 64'(fabric_en), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        lut_cnt = 0;
        sb_cnt  = 0;
        do_start();
        send_frame(1'b0, -1, 56, accepted);
        repeat (2) @(posedge clock);
        #1;
        chk("postrst_done", 64'(done), 64'd1);
        chk("postrst_fabric_en", 64'(fabric_en), 64'd1);
        chk("postrst_word_count", 64'(word_count), 64'd57);
        chk("postrst_lut_writes", 64'(lut_cnt), 64'd24);
        chk("postrst_sb_writes", 64'(sb_cnt), 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
- Sequences configuration of the 8-cell LUT/switch-block shift-register fabric.
- Accepts a framed stream of 32-bit configuration words over a valid/ready handshake and assembles each LUT's 33-bit mem and each switch block's 16-bit configure word.
- Issues per-element write strobes, verifies a trailer checksum, and enables the fabric only after a clean load.
- Sits between the bitstream source (memory reader or host link) and the fabric's configuration storage.

Parameters:
NUM_CELLS, 8, number of fabric cells (bit slices q7..q0)
LUTS_PER_CELL, 3, LUTs per cell
LUT_BITS, 33, LUT mem width; the low word carries bits 31:0 and the high word's bit 0 carries bit 32
SB_BITS, 16, switch-block configure width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a frame load (one-cycle pulse)
cfg_data  in  32  configuration word
cfg_valid  in  1  cfg_data valid
cfg_ready  out  1  loader accepts word this cycle
lut_wdata  out  33  assembled LUT mem
lut_cell  out  3  target cell index
lut_idx  out  2  target LUT within cell (0..2)
lut_we  out  1  LUT write strobe, one cycle
sb_wdata  out  16  switch-block configure value
sb_cell  out  3  target cell index
sb_we  out  1  switch-block write strobe, one cycle
busy  out  1  load in progress
done  out  1  frame loaded and verified
error  out  1  frame rejected
fabric_en  out  1  fabric may clock user data
word_count  out  7  words accepted in the current frame

Behaviour:
- Reset values: all outputs 0. State IDLE. Internal checksum 0.
- Reset mid-load aborts immediately. Stored partial LUT data is discarded and fabric_en stays 0.
- A handshake occurs when cfg_valid and cfg_ready are both 1 on a rising clock edge. cfg_ready is 1 only in LO, HI, SB and CHECK.
- Frame length is NUM_CELLS*(2*LUTS_PER_CELL+1)+1 = 57 words.
- Word order per cell: LUT0 low, LUT0 high, LUT1 low, LUT1 high, LUT2 low, LUT2 high, SB word.
- Cells load highest index first (7 down to 0). Word 57 is the trailer.
- FSM states: IDLE, LO, HI, SB, CHECK, DONE, ERR.
- IDLE: start=1 -> LO with cell=NUM_CELLS-1, lut=0, word_count=0, checksum=0, busy=1, done=0, error=0, fabric_en=0.
- LO, on handshake: latch cfg_data as bits 31:0 -> HI.
- HI, on handshake:
  - If cfg_data[31:1] != 0 -> ERR.
  - Otherwise register lut_wdata={cfg_data[0], low word}, lut_cell and lut_idx, and pulse lut_we on the next cycle.
  - Then go to LO if lut < LUTS_PER_CELL-1, else to SB.
- SB, on handshake:
  - If cfg_data[31:16] != 0 -> ERR.
  - Otherwise register sb_wdata and sb_cell, and pulse sb_we on the next cycle.
  - If cell==0 -> CHECK, else decrement cell, set lut=0 and go to LO.
- Every handshake in LO, HI and SB XORs cfg_data into the checksum and increments word_count.
- CHECK, on handshake: word_count increments. If cfg_data == checksum -> DONE, else -> ERR.
- DONE: busy=0, done=1, fabric_en=1. Hold until start or reset.
- ERR: busy=0, error=1, fabric_en=0. Hold until start or reset.
- start in DONE or ERR restarts exactly as from IDLE and clears done, error and fabric_en on that edge.
- start while busy is ignored.
- Write latency: lut_we and sb_we are high exactly one cycle, the cycle after the completing handshake. lut_wdata, lut_cell, lut_idx, sb_wdata and sb_cell stay stable while their strobe is high.
- Each strobe fires at most once per handshake.
- cfg_valid gaps are legal: the FSM holds state, and no strobes fire without a handshake.
- word_count saturates at 57. It does not count words offered while cfg_ready=0.

Test Plan:
- Valid frame, continuous valid: 56 words plus correct XOR trailer, start at t0 -> 24 lut_we pulses, 8 sb_we pulses with sb_cell 7..0; done=1 and fabric_en=1 on the edge after the trailer handshake; word_count=57.
- Checksum mismatch: same frame with trailer XOR 0x1 -> error=1, done=0, fabric_en=0; all 32 strobes still occurred.
- Reserved bits: cell 5 LUT1 high word = 0x00000003 -> ERR on that handshake; no lut_we for cell 5 LUT1; cfg_ready=0 afterwards.
- Backpressure and gaps: cfg_valid toggling every other cycle -> identical write sequence and data to the continuous case, and no strobe in idle cycles.
- Reset mid-load: reset_n low after 20 words -> all outputs 0 asynchronously; a new start and full frame then completes with done=1.
- Start handling: start pulsed while busy at word 10 -> ignored and the load completes normally; start in DONE -> fabric_en drops, busy=1, word_count=0.
